// File: rtl/matrix_tx_formatter_pkg.sv
// Shared constants and types for the matrix text formatter.
//   DEF_ELEMENT_WIDTH : default element width in bits
//   FMT_MAX_DIGITS    : decimal digit buffer depth for a 16-bit magnitude
//   ASCII_*           : characters used when printing elements
//   fmt_state_e       : formatter FSM states
package matrix_tx_formatter_pkg;

  localparam int unsigned DEF_ELEMENT_WIDTH = 16;
  localparam int unsigned FMT_MAX_DIGITS    = 5;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_EMIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_WAIT_TX = 3'd4
  } fmt_state_e;

endpackage

// File: rtl/matrix_tx_formatter_div10.sv
// One combinational divide-by-ten step, shared by the numeric printers.
//   i_din  : W-bit unsigned dividend
//   o_quot : i_din / 10
//   o_rem  : i_din % 10 (always 0..9)
module div10_step #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_quot,
  output logic [3:0]   o_rem
);

  // Widen first so the constant 10 is representable even for very narrow W.
  logic [31:0] w_ext;

  assign w_ext  = 32'(i_din);
  assign o_quot = W'(w_ext / 32'd10);
  assign o_rem  = 4'(w_ext % 32'd10);

endmodule

// File: rtl/matrix_tx_formatter.sv
// Converts one matrix element to ASCII decimal text and feeds it to the UART
// one character at a time, followed by a space or LF separator.
//   clk, rst_n       : clock, async active-low reset
//   abort            : drop any element in progress, return to idle
//   elem_valid/ready : element handshake from the print stage
//   elem_data        : element value (two's complement when SIGNED_ELEM)
//   elem_last_col    : element ends its row (LF instead of space)
//   elem_last        : element ends the matrix (extra LF)
//   tx_data/tx_start : character and one-cycle send strobe to uart_tx
//   tx_busy          : UART transmitting
//   busy             : element in progress
module matrix_tx_formatter
  import matrix_tx_formatter_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter bit          SIGNED_ELEM   = 1'b1,
  parameter int unsigned MAX_DIGITS    = FMT_MAX_DIGITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     abort,
  input  logic                     elem_valid,
  output logic                     elem_ready,
  input  logic [ELEMENT_WIDTH-1:0] elem_data,
  input  logic                     elem_last_col,
  input  logic                     elem_last,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     busy
);

  localparam int unsigned EW    = ELEMENT_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned IDX_W = $clog2(MAX_DIGITS + 4);

  fmt_state_e       r_state, w_state_nxt;
  logic [EW-1:0]    r_mag;
  logic             r_neg, r_last_col, r_last;
  logic [3:0]       r_buf [MAX_DIGITS];
  logic [CNT_W-1:0] r_ndig;
  logic [IDX_W-1:0] r_char_idx;
  logic [7:0]       r_tx_data;
  logic             r_tx_start, r_busy;

  logic             w_accept, w_conv, w_emit;
  logic [EW-1:0]    w_quot;
  logic [3:0]       w_rem;
  logic [IDX_W-1:0] w_j, w_nchars;
  logic [CNT_W-1:0] w_didx;
  logic [3:0]       w_digit;
  logic [7:0]       w_char;
  logic             w_in_neg;

  div10_step #(.W(EW)) u_div10 (
    .i_din  (r_mag),
    .o_quot (w_quot),
    .o_rem  (w_rem)
  );

  assign w_in_neg = SIGNED_ELEM && elem_data[EW-1];

  // Character at r_char_idx: optional '-', digits MSB first, separator, optional LF.
  always_comb begin
    w_j      = r_char_idx - IDX_W'(r_neg);
    w_didx   = CNT_W'(IDX_W'(r_ndig) - w_j - IDX_W'(1));
    w_nchars = IDX_W'(r_neg) + IDX_W'(r_ndig) + IDX_W'(1) + IDX_W'(r_last);
    w_digit  = 4'd0;
    for (int k = 0; k < int'(MAX_DIGITS); k++) begin
      if (CNT_W'(k) == w_didx) w_digit = r_buf[k];
    end
    if (r_neg && (r_char_idx == '0)) begin
      w_char = ASCII_MINUS;
    end else if (w_j < IDX_W'(r_ndig)) begin
      w_char = ASCII_ZERO + {4'd0, w_digit};
    end else if (w_j == IDX_W'(r_ndig)) begin
      w_char = r_last_col ? ASCII_LF : ASCII_SPACE;
    end else begin
      w_char = ASCII_LF;
    end
  end

  // Next-state and control decode; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_conv      = 1'b0;
    w_emit      = 1'b0;
    elem_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        elem_ready = !abort;
        if (elem_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_conv = 1'b1;
        if (w_quot == '0) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (!tx_busy) begin
          w_emit      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      // Covers the UART's latency before tx_busy rises.
      S_HOLD:    w_state_nxt = S_WAIT_TX;
      S_WAIT_TX: begin
        if (!tx_busy) w_state_nxt = (r_char_idx == w_nchars) ? S_IDLE : S_EMIT;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_accept    = 1'b0;
      w_conv      = 1'b0;
      w_emit      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Element capture, digit conversion and tx handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag      <= '0;
      r_neg      <= 1'b0;
      r_last_col <= 1'b0;
      r_last     <= 1'b0;
      r_ndig     <= '0;
      r_char_idx <= '0;
      r_tx_data  <= 8'd0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      for (int k = 0; k < int'(MAX_DIGITS); k++) r_buf[k] <= 4'd0;
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_tx_start <= w_emit;
      if (abort) begin
        r_mag      <= '0;
        r_neg      <= 1'b0;
        r_ndig     <= '0;
        r_char_idx <= '0;
        for (int k = 0; k < int'(MAX_DIGITS); k++) r_buf[k] <= 4'd0;
      end else begin
        if (w_accept) begin
          // Magnitude is unsigned EW bits, so -2^(EW-1) stays exact.
          r_mag      <= w_in_neg ? (~elem_data + EW'(1)) : elem_data;
          r_neg      <= w_in_neg;
          r_last_col <= elem_last_col;
          r_last     <= elem_last;
          r_ndig     <= '0;
          r_char_idx <= '0;
        end
        if (w_conv) begin
          for (int k = 0; k < int'(MAX_DIGITS); k++) begin
            if (CNT_W'(k) == r_ndig) r_buf[k] <= w_rem;
          end
          r_ndig <= r_ndig + CNT_W'(1);
          r_mag  <= w_quot;
        end
        if (w_emit) begin
          r_tx_data  <= w_char;
          r_char_idx <= r_char_idx + IDX_W'(1);
        end
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign busy     = r_busy;

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// Directed bench for matrix_tx_formatter: a 16-bit instance with a simple
// UART busy model and an 8-bit instance with the UART always idle.
module tb_matrix_tx_formatter;

  logic        clk = 1'b0;
  logic        rst_n, abort;
  logic        elem_valid, elem_ready, elem_last_col, elem_last;
  logic [15:0] elem_data;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, busy;

  logic        elem_valid8, elem_ready8, elem_last_col8, elem_last8;
  logic [7:0]  elem_data8;
  logic [7:0]  tx_data8;
  logic        tx_start8, busy8;
  logic        tx_busy8;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          busy_len = 0;
  int          bcnt = 0;
  bit          dbl = 1'b0;
  logic        prev_start = 1'b0;
  logic [7:0]  cap_q[$];
  int          cap_cyc[$];
  logic [7:0]  cap8[$];
  logic [7:0]  exp_q[$];

  matrix_tx_formatter #(.ELEMENT_WIDTH(16), .SIGNED_ELEM(1'b1), .MAX_DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .elem_last_col(elem_last_col), .elem_last(elem_last),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy)
  );

  matrix_tx_formatter #(.ELEMENT_WIDTH(8), .SIGNED_ELEM(1'b1), .MAX_DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .elem_valid(elem_valid8), .elem_ready(elem_ready8), .elem_data(elem_data8),
    .elem_last_col(elem_last_col8), .elem_last(elem_last8),
    .tx_data(tx_data8), .tx_start(tx_start8), .tx_busy(tx_busy8), .busy(busy8)
  );

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  // Capture strobed characters and model the UART busy window.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      cap_q.push_back(tx_data);
      cap_cyc.push_back(cyc);
      if (prev_start === 1'b1) dbl = 1'b1;
    end
    if (tx_start8 === 1'b1) cap8.push_back(tx_data8);
    prev_start = tx_start;
    if (tx_start === 1'b1 && busy_len > 0) begin
      tx_busy = 1'b1;
      bcnt    = busy_len;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_str(input string tag, input bit which);
    logic [7:0] got[$];
    int n;
    got = which ? cap8 : cap_q;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_c%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic send(input bit which, input logic [15:0] d, input logic lc, input logic lst);
    int k;
    if (which) begin
      elem_data8 = d[7:0]; elem_last_col8 = lc; elem_last8 = lst; elem_valid8 = 1'b1;
    end else begin
      elem_data = d; elem_last_col = lc; elem_last = lst; elem_valid = 1'b1;
    end
    k = 0;
    while (((which ? elem_ready8 : elem_ready) !== 1'b1) && k < 200) begin
      tick();
      k++;
    end
    tick();
    acc_cyc     = cyc;
    elem_valid  = 1'b0;
    elem_valid8 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit which);
    int k;
    k = 0;
    while (((which ? busy8 : busy) !== 1'b0) && k < 3000) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, 32'(which ? busy8 : busy), 32'(0));
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
    cap8.delete();
  endtask

  initial begin
    int k;
    rst_n = 1'b0; abort = 1'b0; tx_busy = 1'b0; tx_busy8 = 1'b0;
    elem_valid = 1'b0; elem_data = '0; elem_last_col = 1'b0; elem_last = 1'b0;
    elem_valid8 = 1'b0; elem_data8 = '0; elem_last_col8 = 1'b0; elem_last8 = 1'b0;
    tick(); tick();
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_elem_ready", 32'(elem_ready), 32'h1);
    chk("rst_busy8", 32'(busy8), 32'h0);
    rst_n = 1'b1;
    tick();

    // Zero prints as a single digit, UART busy 10 cycles per character.
    busy_len = 10; clear_caps();
    send(1'b0, 16'd0, 1'b0, 1'b0);
    wait_idle("zero", 1'b0);
    exp_q = {8'h30, 8'h20};
    check_str("zero", 1'b0);
    chk("zero_ready", 32'(elem_ready), 32'h1);

    // Three digits, last column, first strobe 4 cycles after acceptance.
    busy_len = 0; clear_caps();
    send(1'b0, 16'd123, 1'b1, 1'b0);
    wait_idle("d123", 1'b0);
    exp_q = {8'h31, 8'h32, 8'h33, 8'h0A};
    check_str("d123", 1'b0);
    if (cap_cyc.size() > 0) chk("d123_latency", 32'(cap_cyc[0] - acc_cyc), 32'd4);

    // 8-bit most negative value and 8-bit maximum.
    clear_caps();
    send(1'b1, 16'h0080, 1'b0, 1'b0);
    wait_idle("w8_min", 1'b1);
    exp_q = {8'h2D, 8'h31, 8'h32, 8'h38, 8'h20};
    check_str("w8_min", 1'b1);
    clear_caps();
    send(1'b1, 16'h007F, 1'b1, 1'b0);
    wait_idle("w8_max", 1'b1);
    exp_q = {8'h31, 8'h32, 8'h37, 8'h0A};
    check_str("w8_max", 1'b1);

    // Last element of the matrix gets an extra LF.
    clear_caps();
    send(1'b0, 16'd7, 1'b1, 1'b1);
    wait_idle("last", 1'b0);
    exp_q = {8'h37, 8'h0A, 8'h0A};
    check_str("last", 1'b0);

    // Long busy: no strobe and stable data while tx_busy is high.
    busy_len = 50; clear_caps();
    send(1'b0, 16'd42, 1'b0, 1'b0);
    k = 0;
    while (cap_q.size() < 1 && k < 100) begin tick(); k++; end
    repeat (25) tick();
    chk("hold_tx_data", 32'(tx_data), 32'h34);
    chk("hold_strobes", 32'(cap_q.size()), 32'd1);
    chk("hold_tx_busy", 32'(tx_busy), 32'h1);
    wait_idle("hold", 1'b0);
    exp_q = {8'h34, 8'h32, 8'h20};
    check_str("hold", 1'b0);
    if (cap_cyc.size() > 1) chk("hold_gap", 32'(cap_cyc[1] - cap_cyc[0]), 32'd52);

    // Abort after the second character of 456.
    busy_len = 3; clear_caps();
    send(1'b0, 16'd456, 1'b0, 1'b0);
    k = 0;
    while (cap_q.size() < 2 && k < 200) begin tick(); k++; end
    abort = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ready", 32'(elem_ready), 32'h0);
    elem_data = 16'd5; elem_valid = 1'b1;
    tick();
    abort = 1'b0; elem_valid = 1'b0;
    chk("abort_no_accept", 32'(busy), 32'h0);
    repeat (40) tick();
    chk("abort_strobes", 32'(cap_q.size()), 32'd2);
    chk("abort_ready_back", 32'(elem_ready), 32'h1);

    // Clean restart after abort.
    busy_len = 0; clear_caps();
    send(1'b0, 16'd9, 1'b1, 1'b0);
    wait_idle("restart", 1'b0);
    exp_q = {8'h39, 8'h0A};
    check_str("restart", 1'b0);

    // 16-bit most negative value uses every digit slot.
    clear_caps();
    send(1'b0, 16'h8000, 1'b1, 1'b0);
    wait_idle("w16_min", 1'b0);
    exp_q = {8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38, 8'h0A};
    check_str("w16_min", 1'b0);

    chk("single_cycle_strobe", 32'(dbl), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
